// File: rtl/synth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : synth_pkg                                                      |
// | Purpose : Shared types and constants for the synth PWM output stage and  |
// |           its receive-side decoder (pwm_decoder / edge_sync).            |
// | Contents: PWM_PERIOD, PWM_TIMEOUT, SAMPLE_W, PWM_CNT_W constants,        |
// |           pwm_dec_state_t decoder state type, maj3() majority helper.    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package synth_pkg;

   // PWM frame length in clk cycles (2**SAMPLE_W).
   localparam int PWM_PERIOD  = 256;
   // Cycles without a rising edge before a constant-level frame is declared.
   localparam int PWM_TIMEOUT = 512;
   // Sample width carried by one PWM frame.
   localparam int SAMPLE_W    = 8;
   // Frame-length counter width; must hold PWM_TIMEOUT.
   localparam int PWM_CNT_W   = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      STUCK   = 2'd2
   } pwm_dec_state_t;

   // Three-input majority vote.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage : synth_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : edge_sync                                                      |
// | Purpose : Brings an asynchronous 1-bit input into the clk domain and     |
// |           produces a clean level plus a one-cycle rising-edge strobe.    |
// |           Reusable for keypad and other slow external inputs.           |
// | Macro   : PWM_DEC_GLITCH_FILTER_EN - when defined, a 3-sample majority   |
// |           filter follows the synchronizer; 1-cycle pulses are rejected  |
// |           and latency grows by two cycles.                               |
// | Ports   : clk     - system clock                                         |
// |           n_rst   - asynchronous active-low reset                        |
// |           d_i     - asynchronous input                                   |
// |           level_o - synchronized (filtered) level, aligned with rise_o   |
// |           rise_o  - one-cycle pulse on a 0->1 transition of level        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module edge_sync
   import synth_pkg::*;
(
   input  logic clk,
   input  logic n_rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic rise_q;
   logic w_src;

   // Two-flop synchronizer.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef PWM_DEC_GLITCH_FILTER_EN
   logic hist1_q;
   logic hist2_q;
   logic filt_q;

   // Majority over the current and two previous synchronized samples; a
   // single-cycle pulse can never win the vote.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hist1_q <= 1'b0;
         hist2_q <= 1'b0;
         filt_q  <= 1'b0;
      end else begin
         hist1_q <= sync2_q;
         hist2_q <= hist1_q;
         filt_q  <= maj3(sync2_q, hist1_q, hist2_q);
      end
   end

   assign w_src = filt_q;
`else
   assign w_src = sync2_q;
`endif

   // The edge strobe is registered; prev_q is exported as the level so that
   // level_o and rise_o describe the same sample.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= w_src;
         rise_q <= w_src & ~prev_q;
      end
   end

   assign level_o = prev_q;
   assign rise_o  = rise_q;

endmodule : edge_sync
`default_nettype wire

// File: rtl/pwm_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pwm_decoder                                                    |
// | Purpose : Recovers a WIDTH-bit sample from a fixed-period PWM stream     |
// |           (pin high for `sample` cycles, then low, every PERIOD cycles). |
// |           Constant-level inputs are reported after TIMEOUT cycles and    |
// |           then re-reported once per PERIOD.                              |
// | Macro   : PWM_DEC_GLITCH_FILTER_EN - enables the majority glitch filter  |
// |           inside edge_sync (edge-to-valid latency 6 clk instead of 4).   |
// | Ports   : clk          - system clock                                    |
// |           n_rst        - asynchronous active-low reset                   |
// |           en           - enable; low holds sample_o, clears measurement  |
// |           pwm_i        - PWM stream, asynchronous to clk                 |
// |           sample_o     - last recovered sample                           |
// |           valid_o      - one-cycle pulse when sample_o updates           |
// |           period_err_o - one-cycle pulse when a frame is not PERIOD long |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pwm_decoder
   import synth_pkg::*;
#(
   parameter int PERIOD  = PWM_PERIOD,
   parameter int WIDTH   = SAMPLE_W,
   parameter int TIMEOUT = PWM_TIMEOUT
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             pwm_i,
   output logic [WIDTH-1:0] sample_o,
   output logic             valid_o,
   output logic             period_err_o
);

   localparam int CNT_W = PWM_CNT_W;
   localparam int HI_W  = WIDTH + 1;

   localparam logic [CNT_W-1:0] C_CNT_PERIOD  = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] C_CNT_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);
   localparam logic [HI_W-1:0]  C_HI_PERIOD   = HI_W'(PERIOD);
   localparam logic [HI_W-1:0]  C_HI_ONE      = HI_W'(1);

   logic             w_pwm_s;
   logic             w_rise;
   logic [WIDTH-1:0] w_sat_sample;
   logic [WIDTH-1:0] w_const_sample;

   pwm_dec_state_t   state_q,      state_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [HI_W-1:0]  high_cnt_q,   high_cnt_d;
   logic [WIDTH-1:0] sample_q,     sample_d;
   logic             valid_q,      valid_d;
   logic             perr_q,       perr_d;
   logic             en_prev_q;

   edge_sync u_edge_sync (
      .clk     (clk),
      .n_rst   (n_rst),
      .d_i     (pwm_i),
      .level_o (w_pwm_s),
      .rise_o  (w_rise)
   );

   // high_cnt saturates at PERIOD, so its MSB is set only for a full-high
   // count, which clamps to all-ones.
   assign w_sat_sample   = high_cnt_q[WIDTH] ? {WIDTH{1'b1}} : high_cnt_q[WIDTH-1:0];
   assign w_const_sample = {WIDTH{w_pwm_s}};

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         period_cnt_q <= '0;
         high_cnt_q   <= '0;
         sample_q     <= '0;
         valid_q      <= 1'b0;
         perr_q       <= 1'b0;
         en_prev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         high_cnt_q   <= high_cnt_d;
         sample_q     <= sample_d;
         valid_q      <= valid_d;
         perr_q       <= perr_d;
         en_prev_q    <= en;
      end
   end

   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
      sample_d     = sample_q;
      valid_d      = 1'b0;
      perr_d       = 1'b0;

      if (!en) begin
         state_d      = IDLE;
         period_cnt_d = '0;
         high_cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // An edge coinciding with en rising is not trusted as a
               // frame start.
               if (w_rise && en_prev_q) begin
                  period_cnt_d = C_CNT_ONE;
                  high_cnt_d   = C_HI_ONE;
                  state_d      = MEASURE;
               end
            end

            MEASURE: begin
               // A rise has priority over a simultaneous timeout.
               if (w_rise) begin
                  if (period_cnt_q == C_CNT_PERIOD) begin
                     sample_d = w_sat_sample;
                     valid_d  = 1'b1;
                  end else begin
                     perr_d   = 1'b1;
                  end
                  period_cnt_d = C_CNT_ONE;
                  high_cnt_d   = C_HI_ONE;
               end else if (period_cnt_q == C_CNT_TIMEOUT) begin
                  sample_d     = w_const_sample;
                  valid_d      = 1'b1;
                  // Restart the count so the constant is re-emitted every
                  // PERIOD cycles from here.
                  period_cnt_d = C_CNT_ONE;
                  high_cnt_d   = '0;
                  state_d      = STUCK;
               end else begin
                  if (period_cnt_q != C_CNT_TIMEOUT) begin
                     period_cnt_d = period_cnt_q + C_CNT_ONE;
                  end
                  if (w_pwm_s && (high_cnt_q != C_HI_PERIOD)) begin
                     high_cnt_d = high_cnt_q + C_HI_ONE;
                  end
               end
            end

            STUCK: begin
               if (w_rise) begin
                  period_cnt_d = C_CNT_ONE;
                  high_cnt_d   = C_HI_ONE;
                  state_d      = MEASURE;
               end else if (period_cnt_q == C_CNT_PERIOD) begin
                  valid_d      = 1'b1;
                  period_cnt_d = C_CNT_ONE;
               end else begin
                  period_cnt_d = period_cnt_q + C_CNT_ONE;
               end
            end

            default: begin
               state_d      = IDLE;
               period_cnt_d = '0;
               high_cnt_d   = '0;
            end
         endcase
      end
   end

   assign sample_o     = sample_q;
   assign valid_o      = valid_q;
   assign period_err_o = perr_q;

endmodule : pwm_decoder
`default_nettype wire
